// File: rtl/div_pkg.sv
// Shared widths, state codes and handshake levels for the divider.
package div_pkg;

   localparam int REG_BUS        = 32;
   localparam int DOUBLE_REG_BUS = 64;

   // FSM state codes
   localparam logic [1:0] DIV_FREE    = 2'b00;
   localparam logic [1:0] DIV_BY_ZERO = 2'b01;
   localparam logic [1:0] DIV_ON      = 2'b10;
   localparam logic [1:0] DIV_END     = 2'b11;

   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

   // Operation context captured when a division is accepted.
   typedef struct packed {
      logic                 sgn;      // DIV rather than DIVU
      logic                 op1_neg;  // dividend was negative (signed only)
      logic                 op2_neg;  // divisor was negative (signed only)
      logic [REG_BUS-1:0]   divisor;  // |op2|
   } div_op_t;

   function automatic logic [REG_BUS-1:0] neg32(input logic [REG_BUS-1:0] x);
      return ~x + 32'd1;
   endfunction

   // Magnitude, taken only for signed operations with the sign bit set.
   function automatic logic [REG_BUS-1:0] mag32(input logic sgn, input logic [REG_BUS-1:0] x);
      return (sgn && x[REG_BUS-1]) ? neg32(x) : x;
   endfunction

endpackage

// File: rtl/div_if.sv
// Divide request/response bundle between the execute stage and the divider.
interface div_if;
   import div_pkg::*;

   logic                      signed_div;
   logic [REG_BUS-1:0]        opdata1;
   logic [REG_BUS-1:0]        opdata2;
   logic                      start;
   logic                      annul;
   logic [DOUBLE_REG_BUS-1:0] result;
   logic                      ready;

   // execute stage side
   modport master (output signed_div, opdata1, opdata2, start, annul,
                   input  result, ready);
   // divider side
   modport slave  (input  signed_div, opdata1, opdata2, start, annul,
                   output result, ready);
endinterface

// File: rtl/div.sv
// Multi-cycle restoring divider, one quotient bit per cycle, result {rem, quo}.
module div
   import div_pkg::*;
(
   input  logic clk,
   input  logic rst,
   div_if.slave bus
);

   logic [1:0]                state_q, state_d;
   logic [5:0]                cnt_q, cnt_d;
   logic [64:0]               w_q, w_d;
   div_op_t                   op_q, op_d;
   logic [DOUBLE_REG_BUS-1:0] result_q, result_d;
   logic                      ready_q, ready_d;

   logic [64:0]               w_sh;
   logic [32:0]               trial;
   logic [REG_BUS-1:0]        quo_fix, rem_fix;

   // One restoring step: shift, then trial-subtract the divisor from the top 33 bits.
   assign w_sh  = {w_q[63:0], 1'b0};
   assign trial = w_sh[64:32] - {1'b0, op_q.divisor};

   // Sign correction applied once all 32 quotient bits are in.
   assign quo_fix = (op_q.sgn && (op_q.op1_neg ^ op_q.op2_neg)) ? neg32(w_q[31:0]) : w_q[31:0];
   assign rem_fix = (op_q.sgn && op_q.op1_neg) ? neg32(w_q[63:32]) : w_q[63:32];

   // Next-state and datapath for the FREE/BYZERO/ON/END sequence.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      w_d      = w_q;
      op_d     = op_q;
      result_d = result_q;
      ready_d  = ready_q;
      case (state_q)
         DIV_FREE: begin
            result_d = '0;
            ready_d  = DIV_RESULT_NOT_READY;
            if (bus.start == DIV_START && !bus.annul) begin
               if (bus.opdata2 == '0) begin
                  state_d = DIV_BY_ZERO;
               end else begin
                  state_d      = DIV_ON;
                  cnt_d        = '0;
                  op_d.sgn     = bus.signed_div;
                  op_d.op1_neg = bus.signed_div & bus.opdata1[REG_BUS-1];
                  op_d.op2_neg = bus.signed_div & bus.opdata2[REG_BUS-1];
                  op_d.divisor = mag32(bus.signed_div, bus.opdata2);
                  w_d          = {33'b0, mag32(bus.signed_div, bus.opdata1)};
               end
            end
         end
         DIV_BY_ZERO: begin
            state_d = DIV_END;
            w_d     = '0;
         end
         DIV_ON: begin
            if (bus.annul) begin
               // flush: drop the partial result, nothing is reported
               state_d = DIV_FREE;
               cnt_d   = '0;
               ready_d = DIV_RESULT_NOT_READY;
            end else if (cnt_q != 6'd32) begin
               w_d   = trial[32] ? w_sh : {trial, w_sh[31:1], 1'b1};
               cnt_d = cnt_q + 6'd1;
            end else begin
               // keep the corrected result in W so END can re-present it
               w_d      = {1'b0, rem_fix, quo_fix};
               result_d = {rem_fix, quo_fix};
               ready_d  = DIV_RESULT_READY;
               state_d  = DIV_END;
               cnt_d    = '0;
            end
         end
         DIV_END: begin
            if (bus.start == DIV_START) begin
               ready_d  = DIV_RESULT_READY;
               result_d = w_q[63:0];
            end else begin
               state_d  = DIV_FREE;
               ready_d  = DIV_RESULT_NOT_READY;
               result_d = '0;
            end
         end
         default: state_d = DIV_FREE;
      endcase
   end

   // State registers, asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= DIV_FREE;
         cnt_q    <= '0;
         w_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         ready_q  <= DIV_RESULT_NOT_READY;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         w_q      <= w_d;
         op_q     <= op_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign bus.result = result_q;
   assign bus.ready  = ready_q;

endmodule

// File: tb/tb_div.sv
// Randomized and directed checks of the divider against a timeline/arithmetic model.
module tb_div;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_probe = 1'b0;

   div_if u_if ();

   div u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int to_req = 0;
   int to_seen = 0;

   // literal expectation for the operation in flight
   logic        lit_on = 1'b0;
   logic [63:0] lit_exp = '0;
   string       lit_name = "";

   // Reference result straight from integer arithmetic.
   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] qq, rr;
      if (b == 32'd0) return 64'h0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'b0, a});
         sb = longint'({32'b0, b});
      end
      q  = sa / sb;
      r  = sa % sb;
      qq = q;
      rr = r;
      return {rr[31:0], qq[31:0]};
   endfunction

   // Timeline model: accept, count down latency, present until start drops.
   logic        m_busy, m_byz, m_ready;
   int          m_left;
   logic [63:0] m_val, m_res;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy  <= 1'b0;
         m_byz   <= 1'b0;
         m_left  <= 0;
         m_ready <= 1'b0;
         m_val   <= '0;
         m_res   <= '0;
      end else if (m_ready) begin
         if (!u_if.start) begin
            m_ready <= 1'b0;
            m_res   <= '0;
         end
      end else if (m_busy) begin
         if (u_if.annul && !m_byz) begin
            m_busy <= 1'b0;
         end else if (m_left == 1) begin
            m_busy <= 1'b0;
            if (!m_byz || u_if.start) begin
               m_ready <= 1'b1;
               m_res   <= m_val;
            end
         end else begin
            m_left <= m_left - 1;
         end
      end else if (u_if.start && !u_if.annul) begin
         m_busy <= 1'b1;
         m_byz  <= (u_if.opdata2 == 32'd0);
         m_left <= (u_if.opdata2 == 32'd0) ? 2 : 33;
         m_val  <= ref_div(u_if.signed_div, u_if.opdata1, u_if.opdata2);
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Single compare process: model pins first, then every cycle and on reset probes.
   initial begin
      chk("model_100_7",   ref_div(1'b0, 32'd100, 32'd7),             {32'd2, 32'd14});
      chk("model_m7_2",    ref_div(1'b1, 32'hFFFF_FFF9, 32'd2),        {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      chk("model_min_m1",  ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'h0, 32'h8000_0000});
      chk("model_9_3",     ref_div(1'b0, 32'd9, 32'd3),                {32'd0, 32'd3});
      forever begin
         @(negedge clk or posedge rst_probe);
         chk(rst_probe ? "async_rst_ready"  : "ready",  {63'b0, u_if.ready}, {63'b0, m_ready});
         chk(rst_probe ? "async_rst_result" : "result", u_if.result, m_res);
         if (m_ready && lit_on) chk(lit_name, u_if.result, lit_exp);
         if (to_req != to_seen) begin
            to_seen = to_req;
            vectors++;
            miscompares++;
            $display("FAIL timeout: ready not seen, expected within 60 cycles at %0t", $time);
         end
      end
   end

   task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string nm, input logic has_lit, input logic [63:0] lit);
      logic got;
      @(negedge clk);
      u_if.signed_div = sgn;
      u_if.opdata1    = a;
      u_if.opdata2    = b;
      u_if.start      = 1'b1;
      lit_on          = has_lit;
      lit_exp         = lit;
      lit_name        = nm;
      got = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         // operands must be ignored once the op is accepted
         u_if.opdata1    = $urandom;
         u_if.opdata2    = $urandom;
         u_if.signed_div = $urandom_range(0, 1);
         if (u_if.ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) to_req++;
      repeat (hold) @(negedge clk);
      u_if.start = 1'b0;
      @(negedge clk);
      lit_on = 1'b0;
   endtask

   initial begin
      logic        sgn;
      logic [31:0] a, b;
      u_if.signed_div = 1'b0;
      u_if.opdata1    = '0;
      u_if.opdata2    = '0;
      u_if.start      = 1'b0;
      u_if.annul      = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_op(1'b0, 32'd100, 32'd7, 0, "udiv_100_7", 1'b1, {32'd2, 32'd14});
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1, "sdiv_m7_2", 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_op(1'b0, 32'd5, 32'd0, 1, "div_by_zero", 1'b1, 64'h0);

      // annul on the 10th iteration
      @(negedge clk);
      u_if.signed_div = 1'b0;
      u_if.opdata1    = 32'd1000;
      u_if.opdata2    = 32'd3;
      u_if.start      = 1'b1;
      repeat (10) @(negedge clk);
      u_if.annul = 1'b1;
      u_if.start = 1'b0;
      @(negedge clk);
      u_if.annul = 1'b0;
      repeat (40) @(negedge clk);

      run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, "udiv_max_1", 1'b1, {32'h0, 32'hFFFF_FFFF});
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5, "sdiv_min_m1", 1'b1, {32'h0, 32'h8000_0000});

      // asynchronous reset in the middle of an iteration
      @(negedge clk);
      u_if.signed_div = 1'b0;
      u_if.opdata1    = 32'h1234_5678;
      u_if.opdata2    = 32'd17;
      u_if.start      = 1'b1;
      repeat (15) @(negedge clk);
      #2 rst = 1'b1;
      #1 rst_probe = 1'b1;
      #1 rst_probe = 1'b0;
      @(negedge clk);
      u_if.start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      run_op(1'b0, 32'd9, 32'd3, 0, "udiv_9_3", 1'b1, {32'd0, 32'd3});

      // random mix of signed/unsigned, edge operands and hold lengths
      for (int n = 0; n < 24; n++) begin
         sgn = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       a = 32'h8000_0000;
            1:       a = $urandom_range(0, 255);
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         run_op(sgn, a, b, $urandom_range(0, 3), "random", 1'b0, 64'h0);
      end

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider, the responder side of the execute stage's divide request interface. The execute stage issues a DIV or DIVU by raising a start request with two latched operands. It stalls the pipeline until this block returns a 64-bit result, packed as {remainder, quotient}, which the execute stage forwards on its HI/LO write-request outputs. Restoring division, one quotient bit per cycle, with optional signed correction and annulment on pipeline flush.

## Interface
Parameters: none; widths come from the shared defines (`RegBus` = 32, `DoubleRegBus` = 64).
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high (`RstEnable` = 1)
- signed_div_i  in  1  1 = DIV (two's-complement), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request (`DivStart`); held high by execute stage until result consumed
- annul_i  in  1  cancel in-flight division (flush/exception)
- result_o  out  64  {remainder[63:32], quotient[31:0]}; 0 except in END
- ready_o  out  1  result valid (`DivResultReady`); high only in END

## Operation
- State machine, 2-bit state reg, states: FREE, BYZERO, ON, END. Reset state is FREE.
- Reset values: state = FREE, cnt = 0, result_o = 0, ready_o = 0.
- FREE:
  - If start_i=1 and annul_i=0 and opdata2_i==0: go to BYZERO.
  - If start_i=1 and annul_i=0 and opdata2_i!=0: go to ON, cnt=0.
    - Latch |op1| and |op2|. Magnitude is taken only when signed_div_i=1 and the operand's bit 31 is 1.
    - Latch sign flags and signed_div_i.
    - Working register W[64:0] = {33'b0, |op1|}.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- BYZERO: on the next edge go unconditionally to END with W = 0. Divide-by-zero result is 64'h0.
- ON:
  - annul_i=1: go to FREE, cnt=0, ready_o=0; W is discarded.
  - cnt<32: one iteration, then cnt+1.
    - Shift W left 1.
    - Trial t = W[64:32] − {1'b0,|op2|} (33-bit).
    - If t[32]==0: W[64:32]=t and W[0]=1. Otherwise W[0]=0.
  - cnt==32: finalize and go to END, ready_o=1.
    - quotient = W[31:0], negated if signed and sign(op1)≠sign(op2).
    - remainder = W[63:32], negated if signed and sign(op1)=1.
- END:
  - ready_o=1 and result_o held stable while start_i=1.
  - When start_i=0: go to FREE; on that edge ready_o←0 and result_o←0.
- annul_i is ignored in BYZERO and END. Operand inputs are ignored outside FREE; only the latched copies are used.
- Arithmetic wraps; there is no overflow trap. Signed −2^31 / −1 gives quotient 32'h8000_0000, remainder 0.

## Timing
- Start sampled at edge k (FREE→ON).
  - Iterations run on edges k+1..k+32.
  - The finalize edge is k+33; ready_o and result_o are valid from after edge k+33.
- Divide-by-zero: ready_o is valid from after edge k+2.
- Result persists for at least 1 cycle and then until start_i drops. There is a 1-cycle turnaround in FREE before a new start is accepted.
- Annul seen at any edge while in ON takes effect on that edge; ready_o never rises for the cancelled operation.
- Asynchronous reset at any point forces the reset values immediately; no partial result leaks out.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared defines file (alongside the ALU op and `RegBus` macros) holds:
  - `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2'b00..2'b11)
  - `DivStart`/`DivStop`
  - `DivResultReady`/`DivResultNotReady`
  - `DoubleRegBus`
- Single module, no sub-module. The 33-bit trial subtract is a local combinational net feeding the sequential always block.
- The execute stage owns stall generation and the start/annul drive.

## Test plan
- Unsigned 100 / 7, start at edge k: ready_o rises after edge k+33, result_o = {32'd2, 32'd14}; outputs stay 0 before that.
- Signed −7 / 2 (32'hFFFF_FFF9, 32'd2): quotient 32'hFFFF_FFFD, remainder 32'hFFFF_FFFF.
- 5 / 0: ready_o after edge k+2 with result_o = 64'h0; state passes through BYZERO.
- Annul at 10th iteration: return to FREE, ready_o stays 0. Then unsigned 32'hFFFF_FFFF / 1 yields {32'h0, 32'hFFFF_FFFF}.
- Signed −2^31 / −1 with start_i held 5 cycles past ready: result_o = {32'h0, 32'h8000_0000} stable throughout. Dropping start_i clears ready_o and result_o on the next edge.
- Assert rst asynchronously mid-ON: ready_o = 0 and result_o = 0 before the next clock edge. After release, a new 9 / 3 completes normally = {32'd0, 32'd3}.
